// File: rtl/mips_pkg.sv
// Shared MIPS definitions: width defaults, ALU operation codes, clog2 helper.
package mips_pkg;

  localparam int unsigned WIDTH_DATA_MEM        = 32;
  localparam int unsigned CANT_REGISTROS        = 32;
  localparam int unsigned CANT_BITS_ADDR        = 11;
  localparam int unsigned CANT_BITS_REGISTROS   = 32;
  localparam int unsigned CANT_BITS_ALU_CONTROL = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLLV = 4'b1100;
  localparam logic [3:0] ALU_SRLV = 4'b1101;
  localparam logic [3:0] ALU_LINK = 4'b1110;
  localparam logic [3:0] ALU_SRAV = 4'b1111;

  // Ceiling log2, minimum 1 so a depth of 1 still yields a usable index.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/ejecucion_top_alu.sv
// Combinational 32-bit ALU for the execute stage; all arithmetic wraps modulo 2^W.
module alu
  import mips_pkg::*;
#(
  parameter int unsigned W    = CANT_BITS_REGISTROS,
  parameter int unsigned PCW  = CANT_BITS_ADDR,
  parameter int unsigned CW   = CANT_BITS_ALU_CONTROL
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [4:0]     shamt,
  input  logic [PCW-1:0] pc,
  input  logic [CW-1:0]  ctrl,
  output logic [W-1:0]   result
);

  // Operation select; compares produce a single LSB on an otherwise zero word.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADDU: result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
      ALU_SUBU: result = a - b;
      ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_LUI:  result = b << 16;
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = W'($signed(b) >>> shamt);
      ALU_SLLV: result = b << a[4:0];
      ALU_SRLV: result = b >> a[4:0];
      ALU_SRAV: result = W'($signed(b) >>> a[4:0]);
      ALU_LINK: result = W'(pc);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ejecucion_top.sv
// MIPS execute stage: operand-B mux, destination mux, ALU and EX/MEM register.
// Optional macro EJECUCION_LED_EN: registers the ALU zero flag onto o_led;
// when undefined o_led is tied low and the zero-flag register is omitted.
module ejecucion_top
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH_DATA_MEM_P        = WIDTH_DATA_MEM,
  parameter int unsigned CANT_REGISTROS_P        = CANT_REGISTROS,
  parameter int unsigned CANT_BITS_ADDR_P        = CANT_BITS_ADDR,
  parameter int unsigned CANT_BITS_REGISTROS_P   = CANT_BITS_REGISTROS,
  parameter int unsigned CANT_BITS_ALU_CONTROL_P = CANT_BITS_ALU_CONTROL,
  parameter int unsigned RW                      = clog2(CANT_REGISTROS_P)
) (
  input  logic                               i_clock,
  input  logic                               i_soft_reset,
  input  logic                               i_enable_pipeline,
  input  logic [CANT_BITS_ADDR_P-1:0]        i_adder_pc,
  input  logic [CANT_BITS_REGISTROS_P-1:0]   i_data_A,
  input  logic [CANT_BITS_REGISTROS_P-1:0]   i_data_B,
  input  logic [CANT_BITS_REGISTROS_P-1:0]   i_extension_signo_constante,
  input  logic [RW-1:0]                      i_reg_rs,
  input  logic [RW-1:0]                      i_reg_rt,
  input  logic [RW-1:0]                      i_reg_rd,
  input  logic                               i_RegDst,
  input  logic                               i_RegWrite,
  input  logic                               i_ALUSrc,
  input  logic                               i_MemRead,
  input  logic                               i_MemWrite,
  input  logic                               i_MemtoReg,
  input  logic [CANT_BITS_ALU_CONTROL_P-1:0] i_ALUCtrl,
  output logic                               o_RegWrite,
  output logic                               o_MemRead,
  output logic                               o_MemWrite,
  output logic                               o_MemtoReg,
  output logic [WIDTH_DATA_MEM_P-1:0]        o_result,
  output logic [WIDTH_DATA_MEM_P-1:0]        o_data_write_to_mem,
  output logic [RW-1:0]                      o_registro_destino,
  output logic                               o_led
);

  logic [CANT_BITS_REGISTROS_P-1:0] operand_b_c;
  logic [CANT_BITS_REGISTROS_P-1:0] alu_result_c;
  logic [RW-1:0]                    destino_c;
  logic [RW-1:0]                    unused_reg_rs;

  // rs index travels with the bundle but the execute stage has no use for it.
  assign unused_reg_rs = i_reg_rs;

  // Operand-B and destination-register selection.
  assign operand_b_c = i_ALUSrc ? i_extension_signo_constante : i_data_B;
  assign destino_c   = i_RegDst ? i_reg_rd : i_reg_rt;

  alu #(
    .W   (CANT_BITS_REGISTROS_P),
    .PCW (CANT_BITS_ADDR_P),
    .CW  (CANT_BITS_ALU_CONTROL_P)
  ) u_alu (
    .a      (i_data_A),
    .b      (operand_b_c),
    .shamt  (i_extension_signo_constante[10:6]),
    .pc     (i_adder_pc),
    .ctrl   (i_ALUCtrl),
    .result (alu_result_c)
  );

  // EX/MEM register: loads on enable, holds on stall, async clear dominates.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      o_RegWrite          <= 1'b0;
      o_MemRead           <= 1'b0;
      o_MemWrite          <= 1'b0;
      o_MemtoReg          <= 1'b0;
      o_result            <= '0;
      o_data_write_to_mem <= '0;
      o_registro_destino  <= '0;
    end else if (i_enable_pipeline) begin
      o_RegWrite          <= i_RegWrite;
      o_MemRead           <= i_MemRead;
      o_MemWrite          <= i_MemWrite;
      o_MemtoReg          <= i_MemtoReg;
      o_result            <= WIDTH_DATA_MEM_P'(alu_result_c);
      o_data_write_to_mem <= WIDTH_DATA_MEM_P'(i_data_B);
      o_registro_destino  <= destino_c;
    end
  end

`ifdef EJECUCION_LED_EN
  // Registered zero flag of the ALU result, same load/hold/clear rules.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset)           o_led <= 1'b0;
    else if (i_enable_pipeline) o_led <= (alu_result_c == '0);
  end
`else
  assign o_led = 1'b0;
`endif

endmodule

// File: tb/tb_ejecucion_top.sv
// Self-checking bench for ejecucion_top: vector table through a scoreboard plus
// hand-written reset and stall sequences.
module tb_ejecucion_top;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] pc;
  logic [31:0] da, db, imm;
  logic [4:0]  rs, rt, rd;
  logic        regdst, regwrite, alusrc, memread, memwrite, memtoreg;
  logic [3:0]  aluctrl;
  logic        o_regwrite, o_memread, o_memwrite, o_memtoreg, o_led;
  logic [31:0] o_result, o_wdata;
  logic [4:0]  o_dst;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a, b, imm;
    logic [10:0] pc;
    logic [4:0]  rt, rd;
    logic        regdst, alusrc;
    logic [3:0]  ctrl;
    logic [3:0]  ctl;
    logic [31:0] exp_res;
    logic [4:0]  exp_dst;
  } vec_t;

  typedef struct {
    logic [31:0] res, wdata;
    logic [4:0]  dst;
    logic [3:0]  ctl;
    logic        led;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  ejecucion_top dut (
    .i_clock                     (clk),
    .i_soft_reset                (rst),
    .i_enable_pipeline           (en),
    .i_adder_pc                  (pc),
    .i_data_A                    (da),
    .i_data_B                    (db),
    .i_extension_signo_constante (imm),
    .i_reg_rs                    (rs),
    .i_reg_rt                    (rt),
    .i_reg_rd                    (rd),
    .i_RegDst                    (regdst),
    .i_RegWrite                  (regwrite),
    .i_ALUSrc                    (alusrc),
    .i_MemRead                   (memread),
    .i_MemWrite                  (memwrite),
    .i_MemtoReg                  (memtoreg),
    .i_ALUCtrl                   (aluctrl),
    .o_RegWrite                  (o_regwrite),
    .o_MemRead                   (o_memread),
    .o_MemWrite                  (o_memwrite),
    .o_MemtoReg                  (o_memtoreg),
    .o_result                    (o_result),
    .o_data_write_to_mem         (o_wdata),
    .o_registro_destino          (o_dst),
    .o_led                       (o_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic exp_led(input logic [31:0] r);
`ifdef EJECUCION_LED_EN
    return (r == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm_v, input logic alusrc_v, input logic [10:0] pc_v,
                              input logic [31:0] exp_res);
    vec_t v;
    v.a = a; v.b = b; v.imm = imm_v; v.alusrc = alusrc_v; v.pc = pc_v; v.ctrl = ctrl;
    v.rt = 5'd2; v.rd = 5'd3; v.regdst = 1'b0; v.ctl = 4'd0;
    v.exp_res = exp_res; v.exp_dst = 5'd2;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] r, input logic [31:0] w,
                               input logic [4:0] d, input logic [3:0] c, input logic l);
    check({tag, ".result"}, o_result, r);
    check({tag, ".wdata"},  o_wdata, w);
    check({tag, ".dst"},    32'(o_dst), 32'(d));
    check({tag, ".ctl"},    32'({o_regwrite, o_memread, o_memwrite, o_memtoreg}), 32'(c));
    check({tag, ".led"},    32'(o_led), 32'(l));
  endtask

  // Drive one vector on the falling edge and queue what the register must show.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    da = v.a; db = v.b; imm = v.imm; pc = v.pc; rt = v.rt; rd = v.rd;
    regdst = v.regdst; alusrc = v.alusrc; aluctrl = v.ctrl;
    {regwrite, memread, memwrite, memtoreg} = v.ctl;
    e.res = v.exp_res; e.wdata = v.b; e.dst = v.exp_dst; e.ctl = v.ctl; e.led = exp_led(v.exp_res);
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty got 0x%08h expected entry", tag, o_result);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.res, e.wdata, e.dst, e.ctl, e.led);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; en = 1'b1;
    pc = 11'd7; da = 32'hDEAD_BEEF; db = 32'h1234_5678; imm = 32'h0000_0FFF;
    rs = 5'd9; rt = 5'd4; rd = 5'd5;
    regdst = 1'b1; regwrite = 1'b1; alusrc = 1'b0; memread = 1'b1; memwrite = 1'b1; memtoreg = 1'b1;
    aluctrl = ALU_ADDU;

    // Reset held with live inputs: outputs stay cleared across edges.
    #2;
    check_outputs("reset_init", 32'd0, 32'd0, 5'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    check_outputs("reset_held", 32'd0, 32'd0, 5'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table.
    vecs.push_back(mk(ALU_ADDU, 32'd1, 32'd2, 32'd0, 1'b0, 11'd0, 32'd3));
    vecs.push_back(mk(ALU_ADDU, 32'd1, 32'd2, 32'd20, 1'b1, 11'd0, 32'd21));
    vecs.push_back(mk(ALU_LUI,  32'd1, 32'd2, 32'd20, 1'b1, 11'd0, 32'h0014_0000));
    vecs.push_back(mk(ALU_LINK, 32'd1, 32'd2, 32'd20, 1'b1, 11'd5, 32'd5));
    vecs.push_back(mk(ALU_SLT,  32'd1, 32'd2, 32'd20, 1'b1, 11'd0, 32'd1));
    vecs.push_back(mk(ALU_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 11'd0, 32'd0));
    vecs.push_back(mk(ALU_SLT,  32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0, 1'b0, 11'd0, 32'd1));
    vecs.push_back(mk(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 11'd0, 32'd1));
    vecs.push_back(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 11'd0, 32'd0));
    vecs.push_back(mk(ALU_SUBU, 32'd5, 32'd5, 32'd0, 1'b0, 11'd0, 32'd0));
    vecs.push_back(mk(ALU_SUBU, 32'd0, 32'd1, 32'd0, 1'b0, 11'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 11'd0, 32'h0000_F000));
    vecs.push_back(mk(ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 11'd0, 32'h0000_FFF0));
    vecs.push_back(mk(ALU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 11'd0, 32'h0000_0FF0));
    vecs.push_back(mk(ALU_NOR,  32'd0, 32'd0, 32'd0, 1'b0, 11'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 11'd0, 32'd0));
    vecs.push_back(mk(ALU_SLL,  32'd0, 32'd1, 32'h0000_0100, 1'b0, 11'd0, 32'd16));
    vecs.push_back(mk(ALU_SRL,  32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 11'd0, 32'h0800_0000));
    vecs.push_back(mk(ALU_SRA,  32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 11'd0, 32'hF800_0000));
    vecs.push_back(mk(ALU_SLLV, 32'd8, 32'd1, 32'd0, 1'b0, 11'd0, 32'h0000_0100));
    vecs.push_back(mk(ALU_SRLV, 32'd31, 32'h8000_0000, 32'd0, 1'b0, 11'd0, 32'd1));
    vecs.push_back(mk(ALU_SRAV, 32'd31, 32'h8000_0000, 32'd0, 1'b0, 11'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(ALU_SRAV, 32'd36, 32'h8000_0000, 32'd0, 1'b0, 11'd0, 32'hF800_0000));

    // Destination mux and control pass-through patterns on top of the table.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.ctl = 4'(i);
      v.regdst = i[0];
      v.exp_dst = v.regdst ? v.rd : v.rt;
      vecs[i] = v;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      collect($sformatf("vec%0d", i));
    end

    // Stall: load A=0 (result 2), hold across a changed input, update on re-enable.
    v = mk(ALU_ADDU, 32'd0, 32'd2, 32'd0, 1'b0, 11'd0, 32'd2);
    v.ctl = 4'b1010;
    apply(v);
    collect("stall_load");
    @(negedge clk);
    en = 1'b0; da = 32'd1; rd = 5'd7; regdst = 1'b1; {regwrite, memread, memwrite, memtoreg} = 4'b0101;
    @(posedge clk); #1;
    check_outputs("stall_hold", 32'd2, 32'd2, 5'd2, 4'b1010, exp_led(32'd2));
    @(posedge clk); #1;
    check_outputs("stall_hold2", 32'd2, 32'd2, 5'd2, 4'b1010, exp_led(32'd2));
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check_outputs("stall_release", 32'd3, 32'd2, 5'd7, 4'b0101, exp_led(32'd3));

    // Zero result loaded, then reset mid-cycle clears everything without a clock edge.
    v = mk(ALU_SUBU, 32'd5, 32'd5, 32'd0, 1'b0, 11'd0, 32'd0);
    v.ctl = 4'b1111; v.regdst = 1'b1; v.exp_dst = 5'd3;
    apply(v);
    collect("zero_load");
    v = mk(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 1'b0, 11'd0, 32'hA5A5_5A5A);
    v.ctl = 4'b1111;
    apply(v);
    collect("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check_outputs("reset_async", 32'd0, 32'd0, 5'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    check_outputs("reset_dominates_en", 32'd0, 32'd0, 5'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    v = mk(ALU_ADDU, 32'd1, 32'd2, 32'd0, 1'b0, 11'd0, 32'd3);
    v.ctl = 4'b0011;
    apply(v);
    collect("post_reset");

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
